// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard/forwarding control slice.
package pipeline_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 5;

  // ALU operand source selects
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_stage_record.sv
// One pipeline stage's hazard record: {valid, RegWrite, MemRead, dest, rs, rt}.
// clear wins over load so a bubble/flush always lands as an all-zero record.
module hazard_stage_record #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] rec_in,
  output logic [W-1:0] rec_out
);

  logic [W-1:0] rec_d, rec_q;

  // next record: clear to zero, load new, or hold
  always_comb begin
    rec_d = rec_q;
    if (clear)     rec_d = '0;
    else if (load) rec_d = rec_in;
  end

  // record register, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) rec_q <= '0;
    else       rec_q <= rec_d;
  end

  assign rec_out = rec_q;

endmodule

// File: rtl/execution_hazard_controller.sv
// EX-stage hazard control: operand forward selects, load-use / RAW stall,
// taken-branch flush and saturating stall/flush counters. Keeps private
// EX/MEM/WB records so no extra pipeline-register fields are needed.
module execution_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              mem_PCSrc,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              flush_ifid,
  output logic              flush_exmem,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int NSTG  = 3;              // 0: EX, 1: MEM, 2: WB
  localparam int REC_W = 3 + 3*REG_AW;
  localparam int V_B   = REC_W-1;
  localparam int RW_B  = REC_W-2;
  localparam int MR_B  = REC_W-3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // a register match; $0 never matches
  function automatic logic hit(input logic en, input logic [REG_AW-1:0] dest,
                               input logic [REG_AW-1:0] src);
    return en && (dest == src) && (dest != '0);
  endfunction

  // ---------------- stage records ----------------
  logic [NSTG-1:0][REC_W-1:0] stg_in, stg_q;
  logic [NSTG-1:0]            stg_clr;
  logic [REC_W-1:0]           id_rec;

  assign id_rec = id_valid ? {1'b1, id_RegWrite, id_MemRead, id_dest, id_rs, id_rt} : '0;

  // records shift ID->EX->MEM->WB; bubble clears EX, flush clears MEM
  always_comb begin
    stg_in[0]  = id_rec;
    stg_in[1]  = stg_q[0];
    stg_in[2]  = stg_q[1];
    stg_clr[0] = idex_bubble;
    stg_clr[1] = flush_exmem;
    stg_clr[2] = 1'b0;
  end

  for (genvar g = 0; g < NSTG; g++) begin : g_rec
    hazard_stage_record #(.W(REC_W)) u_rec (
      .clk     (clk),
      .reset   (reset),
      .load    (1'b1),
      .clear   (stg_clr[g]),
      .rec_in  (stg_in[g]),
      .rec_out (stg_q[g])
    );
  end

  logic              ex_v, ex_rw, ex_mr, mem_rw, wb_rw;
  logic [REG_AW-1:0] ex_dest, ex_rs, ex_rt, mem_dest, wb_dest;

  assign ex_v     = stg_q[0][V_B];
  assign ex_rw    = stg_q[0][RW_B];
  assign ex_mr    = stg_q[0][MR_B];
  assign ex_dest  = stg_q[0][3*REG_AW-1:2*REG_AW];
  assign ex_rs    = stg_q[0][2*REG_AW-1:REG_AW];
  assign ex_rt    = stg_q[0][REG_AW-1:0];
  assign mem_rw   = stg_q[1][RW_B];
  assign mem_dest = stg_q[1][3*REG_AW-1:2*REG_AW];
  assign wb_rw    = stg_q[2][RW_B];
  assign wb_dest  = stg_q[2][3*REG_AW-1:2*REG_AW];

  logic unused_fields;
  assign unused_fields = ^{stg_q[1][V_B], stg_q[1][MR_B], stg_q[1][2*REG_AW-1:0],
                           stg_q[2][V_B], stg_q[2][MR_B], stg_q[2][2*REG_AW-1:0]};

  // ---------------- forwarding ----------------
  // EX/MEM result is newer than MEM/WB, so it takes priority
  always_comb begin
    forward_a = FWD_REGFILE;
    forward_b = FWD_REGFILE;
    if (FWD_EN != 0 && ex_v) begin
      if (hit(mem_rw, mem_dest, ex_rs))     forward_a = FWD_EXMEM;
      else if (hit(wb_rw, wb_dest, ex_rs))  forward_a = FWD_MEMWB;
      if (hit(mem_rw, mem_dest, ex_rt))     forward_b = FWD_EXMEM;
      else if (hit(wb_rw, wb_dest, ex_rt))  forward_b = FWD_MEMWB;
    end
  end

  // ---------------- hazard detect ----------------
  hz_state_e state_d, state_q;
  logic      dep_ex_ld, dep_ex_wr, dep_mem_wr, hazard, take_br;

  assign dep_ex_ld  = hit(ex_mr, ex_dest, id_rs)  || (id_uses_rt && hit(ex_mr, ex_dest, id_rt));
  assign dep_ex_wr  = hit(ex_rw, ex_dest, id_rs)  || (id_uses_rt && hit(ex_rw, ex_dest, id_rt));
  assign dep_mem_wr = hit(mem_rw, mem_dest, id_rs) || (id_uses_rt && hit(mem_rw, mem_dest, id_rt));

  // WB is not checked: the register file writes before it reads.
  // The cycle after a flush holds only flushed records, so nothing can hazard.
  assign hazard  = id_valid && (state_q != FLUSH) &&
                   ((FWD_EN != 0) ? dep_ex_ld : (dep_ex_wr || dep_mem_wr));
  assign take_br = mem_PCSrc && (state_q != FLUSH);

  // control outputs: flush beats stall
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    flush_exmem = 1'b0;
    if (take_br) begin
      idex_bubble = 1'b1;
      flush_ifid  = 1'b1;
      flush_exmem = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // ---------------- state and counters ----------------
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // next state and saturating counter updates
  always_comb begin
    if (take_br)     state_d = FLUSH;
    else if (hazard) state_d = STALL;
    else             state_d = RUN;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (take_br && flush_cnt_q != CNT_MAX)   flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // FSM state and counters, synchronous reset back to RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
